// File: rtl/cfg_desc_reader.sv
// -----------------------------------------------------------------------------
// cfg_desc_reader
//
// Read-only descriptor-table responder. The core's build-time configuration is
// folded into a small table of 32-bit words at elaboration. A requester reads
// words over a valid/ready channel. Responses are queued in a 2-entry FIFO, so
// the requester is decoupled from the response consumer.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   req_valid_i  request valid
//   req_ready_o  request accepted when valid & ready (FIFO not full)
//   req_addr_i   byte address
//   req_we_i     write attempt (always answered with an error)
//   rsp_valid_o  response valid (FIFO head present)
//   rsp_ready_i  response consumed when valid & ready
//   rsp_data_o   read data (0 on error)
//   rsp_err_o    misaligned, out-of-range or write
//   err_cnt_o    saturating count of error responses pushed
// -----------------------------------------------------------------------------
module cfg_desc_reader #(
    parameter int          ADDR_W    = 8,
    parameter int          NUM_WORDS = 16,
    parameter logic [31:0] VERSION   = 32'h1,
    parameter logic [31:0] ISA_EXT   = 32'h0,
    parameter int          XLEN      = 32,
    parameter int          VLEN      = 32,
    parameter int          NR_COMMIT = 2,
    parameter int          NR_SB     = 8,
    parameter int          IC_BYTES  = 16384,
    parameter int          IC_WAYS   = 4,
    parameter int          IC_LINE   = 128,
    parameter int          DC_BYTES  = 32768,
    parameter int          DC_WAYS   = 8,
    parameter int          DC_LINE   = 128,
    parameter int          BTB       = 32,
    parameter int          BHT       = 128,
    parameter int          RAS       = 2,
    parameter int          NR_PMP    = 8,
    parameter int          WBUF      = 8,
    parameter int          DC_TYPE   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic [7:0]        err_cnt_o
);

    // 32-bit copies of the integer parameters so each field can be sliced
    // down to its width in the table.
    localparam logic [31:0] P_XLEN      = 32'(XLEN);
    localparam logic [31:0] P_VLEN      = 32'(VLEN);
    localparam logic [31:0] P_NR_COMMIT = 32'(NR_COMMIT);
    localparam logic [31:0] P_NR_SB     = 32'(NR_SB);
    localparam logic [31:0] P_IC_BYTES  = 32'(IC_BYTES);
    localparam logic [31:0] P_IC_WAYS   = 32'(IC_WAYS);
    localparam logic [31:0] P_IC_LINE   = 32'(IC_LINE);
    localparam logic [31:0] P_DC_BYTES  = 32'(DC_BYTES);
    localparam logic [31:0] P_DC_WAYS   = 32'(DC_WAYS);
    localparam logic [31:0] P_DC_LINE   = 32'(DC_LINE);
    localparam logic [31:0] P_BTB       = 32'(BTB);
    localparam logic [31:0] P_BHT       = 32'(BHT);
    localparam logic [31:0] P_RAS       = 32'(RAS);
    localparam logic [31:0] P_NR_PMP    = 32'(NR_PMP);
    localparam logic [31:0] P_WBUF      = 32'(WBUF);
    localparam logic [31:0] P_DC_TYPE   = 32'(DC_TYPE);
    localparam logic [31:0] LIMIT_BYTES = 32'(NUM_WORDS * 4);

    // Descriptor table contents; words past 9 read as zero.
    function automatic logic [31:0] table_word(input logic [31:0] idx);
        logic [31:0] w;
        case (idx)
            32'd0:   w = 32'h4356_4136;
            32'd1:   w = VERSION;
            32'd2:   w = ISA_EXT;
            32'd3:   w = {P_XLEN[7:0], P_VLEN[7:0], P_NR_COMMIT[7:0], P_NR_SB[7:0]};
            32'd4:   w = P_IC_BYTES;
            32'd5:   w = {P_IC_WAYS[15:0], P_IC_LINE[15:0]};
            32'd6:   w = P_DC_BYTES;
            32'd7:   w = {P_DC_WAYS[15:0], P_DC_LINE[15:0]};
            32'd8:   w = {P_BTB[15:0], P_BHT[15:0]};
            32'd9:   w = {P_RAS[7:0], P_NR_PMP[7:0], P_WBUF[7:0], P_DC_TYPE[7:0]};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // FIFO storage: slot 0 is always the head and drives rsp_* directly.
    logic [1:0]  count_q, count_d;
    logic [31:0] slot0_data_q, slot0_data_d;
    logic        slot0_err_q, slot0_err_d;
    logic [31:0] slot1_data_q, slot1_data_d;
    logic        slot1_err_q, slot1_err_d;
    logic        valid_q;
    logic        ready_q;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [31:0] addr_ext_s;
    logic        req_err_s;
    logic [31:0] req_data_s;
    logic        push_s;
    logic        pop_s;

    // Decode the incoming request into its response word and error flag.
    always_comb begin
        addr_ext_s = 32'(req_addr_i);
        req_err_s  = (req_addr_i[1:0] != 2'b00) || (addr_ext_s >= LIMIT_BYTES) || req_we_i;
        if (req_err_s) begin
            req_data_s = 32'h0000_0000;
        end else begin
            req_data_s = table_word({2'b00, addr_ext_s[31:2]});
        end
        push_s = req_valid_i & ready_q;
        pop_s  = valid_q & rsp_ready_i;
    end

    // FIFO and error-counter next state. Push needs count<2 and pop needs
    // count>=1, so push+pop together only happens at count==1.
    always_comb begin
        count_d      = count_q;
        slot0_data_d = slot0_data_q;
        slot0_err_d  = slot0_err_q;
        slot1_data_d = slot1_data_q;
        slot1_err_d  = slot1_err_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_data_d = req_data_s;
                    slot0_err_d  = req_err_s;
                    count_d      = 2'd1;
                end else begin
                    slot1_data_d = req_data_s;
                    slot1_err_d  = req_err_s;
                    count_d      = 2'd2;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    slot0_data_d = slot1_data_q;
                    slot0_err_d  = slot1_err_q;
                    slot1_data_d = 32'h0000_0000;
                    slot1_err_d  = 1'b0;
                    count_d      = 2'd1;
                end else begin
                    // Empty FIFO presents zeros on the response lines.
                    slot0_data_d = 32'h0000_0000;
                    slot0_err_d  = 1'b0;
                    count_d      = 2'd0;
                end
            end
            2'b11: begin
                slot0_data_d = req_data_s;
                slot0_err_d  = req_err_s;
            end
            default: begin
                count_d = count_q;
            end
        endcase

        if (push_s && req_err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; valid/ready are registered from the next count so the
    // outputs carry no combinational path from the request side.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= 2'd0;
            slot0_data_q <= 32'h0000_0000;
            slot0_err_q  <= 1'b0;
            slot1_data_q <= 32'h0000_0000;
            slot1_err_q  <= 1'b0;
            valid_q      <= 1'b0;
            ready_q      <= 1'b1;
            err_cnt_q    <= 8'h00;
        end else begin
            count_q      <= count_d;
            slot0_data_q <= slot0_data_d;
            slot0_err_q  <= slot0_err_d;
            slot1_data_q <= slot1_data_d;
            slot1_err_q  <= slot1_err_d;
            valid_q      <= (count_d != 2'd0);
            ready_q      <= (count_d != 2'd2);
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = slot0_data_q;
    assign rsp_err_o   = slot0_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cfg_desc_reader.sv
// Scoreboard bench for cfg_desc_reader: stimulus pushes expected responses,
// a negedge monitor pops and compares on every rsp handshake.
module tb_cfg_desc_reader;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_addr_i;
    logic        req_we_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic [7:0]  err_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rx   = 0;
    int last_wait;
    logic [32:0] exp_q[$];

    cfg_desc_reader dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rsp: got err=%0b data=%h, expected none", rsp_err_o, rsp_data_o);
            end else begin
                chk("rsp", {rsp_err_o, rsp_data_o}, exp_q.pop_front());
            end
        end
    end

    // Issue one request (called at posedge+1); waits up to 50 cycles for ready.
    task automatic issue(input logic [7:0] a, input logic we, input logic [31:0] d, input logic e);
        int w = 0;
        req_addr_i  = a;
        req_we_i    = we;
        req_valid_i = 1'b1;
        @(negedge clk);
        while (!req_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (!req_ready_o) begin
            chk("req_accept_timeout", {32'd0, req_ready_o}, 33'd1);
        end else begin
            exp_q.push_back({e, d});
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 33'(exp_q.size()), 33'd0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  t2_addr [11] = '{8'h24, 8'h14, 8'h0C, 8'h04, 8'h08, 8'h10,
                                  8'h18, 8'h1C, 8'h20, 8'h28, 8'h3C};
    logic [31:0] t2_data [11] = '{32'h0208_0800, 32'h0004_0080, 32'h2020_0208,
                                  32'h0000_0001, 32'h0000_0000, 32'h0000_4000,
                                  32'h0000_8000, 32'h0008_0080, 32'h0020_0080,
                                  32'h0000_0000, 32'h0000_0000};

    initial begin
        int rx0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 8'h00; req_we_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {32'd0, rsp_valid_o}, 33'd0);
        chk("rst_data_err", {rsp_err_o, rsp_data_o}, 33'd0);
        chk("rst_errcnt", {25'd0, err_cnt_o}, 33'd0);
        chk("rst_ready", {32'd0, req_ready_o}, 33'd1);
        @(posedge clk); #1;

        // 1: read magic word, visible the next cycle
        issue(8'h00, 1'b0, 32'h4356_4136, 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", {32'd0, rsp_valid_o}, 33'd1);
        @(posedge clk); #1;

        // 2: table contents
        for (int i = 0; i < 11; i++) issue(t2_addr[i], 1'b0, t2_data[i], 1'b0);
        drain();

        // 3: error cases
        issue(8'h02, 1'b0, 32'h0, 1'b1);
        issue(8'h40, 1'b0, 32'h0, 1'b1);
        issue(8'h00, 1'b1, 32'h0, 1'b1);
        drain();
        chk("t3_errcnt", {25'd0, err_cnt_o}, 33'd3);

        // 4: backpressure, FIFO full after two
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 8'h00;
        @(negedge clk);
        chk("t4_acc0", {32'd0, req_ready_o}, 33'd1);
        exp_q.push_back({1'b0, 32'h4356_4136});
        @(posedge clk); #1 req_addr_i = 8'h04;
        @(negedge clk);
        chk("t4_acc1", {32'd0, req_ready_o}, 33'd1);
        exp_q.push_back({1'b0, 32'h0000_0001});
        @(posedge clk); #1 req_addr_i = 8'h24;
        @(negedge clk);
        chk("t4_full", {32'd0, req_ready_o}, 33'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_full_hold", {32'd0, req_ready_o}, 33'd0);
        chk("t4_head_stable", {rsp_err_o, rsp_data_o}, {1'b0, 32'h4356_4136});
        @(posedge clk); #1 rsp_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_full_while_pop", {32'd0, req_ready_o}, 33'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_reaccept", {32'd0, req_ready_o}, 33'd1);
        exp_q.push_back({1'b0, 32'h0208_0800});
        @(posedge clk); #1 req_valid_i = 1'b0;
        drain();

        // 5: streaming, one response per cycle
        rx0 = n_rx;
        for (int i = 0; i < 10; i++) begin
            issue(t2_addr[i], 1'b0, t2_data[i], 1'b0);
            chk("t5_no_stall", 33'(last_wait), 33'd0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        chk("t5_rx_count", 33'(n_rx - rx0), 33'd10);
        drain();

        // 6: reset drops queued entries and clears the counter
        rsp_ready_i = 1'b0;
        issue(8'h00, 1'b0, 32'h4356_4136, 1'b0);
        issue(8'h04, 1'b0, 32'h0000_0001, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_valid_after_rst", {32'd0, rsp_valid_o}, 33'd0);
        chk("t6_errcnt_after_rst", {25'd0, err_cnt_o}, 33'd0);
        rsp_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) issue(8'h81, 1'b0, 32'h0, 1'b1);
        drain();
        chk("t6_errcnt_sat", {25'd0, err_cnt_o}, 33'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
